// File: rtl/mult_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_div_pkg : state encoding, opcodes and sign helpers            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mult_div_pkg;

  // Helpers work at this width; callers extend into it and truncate back.
  localparam int MAX_WIDTH = 64;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdState_t;

  function automatic logic [MAX_WIDTH-1:0] absVal(input logic [MAX_WIDTH-1:0] x);
    return x[MAX_WIDTH-1] ? (~x + MAX_WIDTH'(1)) : x;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] condNeg(input logic neg,
                                                   input logic [MAX_WIDTH-1:0] x);
    return neg ? (~x + MAX_WIDTH'(1)) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_div_datapath : Booth multiply / restoring divide step logic   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mult_div_datapath
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic             stepMult,
  input  logic             stepDiv,
  input  logic             fix,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // rMcand holds the multiplicand for MULT and |divisor| for DIV;
  // rPHi/rPLo are the Booth product halves or remainder/quotient.
  logic [WIDTH-1:0] rMcand, rPHi, rPLo, rHi, rLo;
  logic             rQm1, rOp, rNegQ, rNegR;

  logic [MAX_WIDTH-1:0] wAExt, wBExt;
  logic [WIDTH-1:0]     wAbsA, wAbsB;
  logic [WIDTH:0]       wMcandX, wPHiX, wBoothSum;
  logic [WIDTH:0]       wShift, wTrial;
  logic                 wFits;

  assign wAExt = {{(MAX_WIDTH-WIDTH){a[WIDTH-1]}}, a};
  assign wBExt = {{(MAX_WIDTH-WIDTH){b[WIDTH-1]}}, b};
  assign wAbsA = WIDTH'(absVal(wAExt));
  assign wAbsB = WIDTH'(absVal(wBExt));

  assign wMcandX = {rMcand[WIDTH-1], rMcand};
  assign wPHiX   = {rPHi[WIDTH-1], rPHi};

  always_comb begin
    wBoothSum = wPHiX;
    case ({rPLo[0], rQm1})
      2'b01:   wBoothSum = wPHiX + wMcandX;
      2'b10:   wBoothSum = wPHiX - wMcandX;
      default: wBoothSum = wPHiX;
    endcase
  end

  // Remainder stays below the divisor (<= 2^(W-1)), so the shifted value
  // never reaches bit W and the borrow alone decides the quotient bit.
  assign wShift = {rPHi, rPLo[WIDTH-1]};
  assign wTrial = wShift - {1'b0, rMcand};
  assign wFits  = ~wTrial[WIDTH];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rMcand <= '0;
      rPHi   <= '0;
      rPLo   <= '0;
      rQm1   <= 1'b0;
      rOp    <= OP_MULT;
      rNegQ  <= 1'b0;
      rNegR  <= 1'b0;
      rHi    <= '0;
      rLo    <= '0;
    end else begin
      if (load) begin
        rOp   <= op;
        rPHi  <= '0;
        rQm1  <= 1'b0;
        rNegQ <= a[WIDTH-1] ^ b[WIDTH-1];
        rNegR <= a[WIDTH-1];
        if (op == OP_DIV) begin
          rMcand <= wAbsB;
          rPLo   <= wAbsA;
        end else begin
          rMcand <= a;
          rPLo   <= b;
        end
      end else if (stepMult) begin
        rPHi <= wBoothSum[WIDTH:1];
        rPLo <= {wBoothSum[0], rPLo[WIDTH-1:1]};
        rQm1 <= rPLo[0];
      end else if (stepDiv) begin
        rPHi <= wFits ? wTrial[WIDTH-1:0] : wShift[WIDTH-1:0];
        rPLo <= {rPLo[WIDTH-2:0], wFits};
      end

      if (fix) begin
        if (rOp == OP_DIV) begin
          rHi <= WIDTH'(condNeg(rNegR, {{(MAX_WIDTH-WIDTH){1'b0}}, rPHi}));
          rLo <= WIDTH'(condNeg(rNegQ, {{(MAX_WIDTH-WIDTH){1'b0}}, rPLo}));
        end else begin
          rHi <= rPHi;
          rLo <= rPLo;
        end
      end
    end
  end

  assign hi = rHi;
  assign lo = rLo;

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_div_unit : iterative signed MULT/DIV engine with HI/LO        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdState_t         rState, wNext;
  logic [CNT_W-1:0] rCount;
  logic             rDivZero;
  logic             wDivByZero, wLoad, wStepMult, wStepDiv, wFix;

  assign wDivByZero = (Op == OP_DIV) && (B == '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rState <= IDLE;
    else        rState <= wNext;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rCount   <= '0;
      rDivZero <= 1'b0;
    end else if (rState == IDLE && Start) begin
      rCount   <= CNT_W'(WIDTH);
      rDivZero <= wDivByZero;
    end else if (rState == MULT || rState == DIV) begin
      rCount   <= rCount - CNT_W'(1);
    end
  end

  always_comb begin
    wNext     = rState;
    Busy      = 1'b1;
    Done      = 1'b0;
    DivZero   = 1'b0;
    wLoad     = 1'b0;
    wStepMult = 1'b0;
    wStepDiv  = 1'b0;
    wFix      = 1'b0;
    unique case (rState)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          // Divide by zero skips the datapath so Hi/Lo keep their old values.
          if (wDivByZero) begin
            wNext = DONE;
          end else begin
            wLoad = 1'b1;
            wNext = (Op == OP_DIV) ? DIV : MULT;
          end
        end
      end
      MULT: begin
        wStepMult = 1'b1;
        if (rCount == CNT_W'(1)) wNext = FIX;
      end
      DIV: begin
        wStepDiv = 1'b1;
        if (rCount == CNT_W'(1)) wNext = FIX;
      end
      FIX: begin
        wFix  = 1'b1;
        wNext = DONE;
      end
      DONE: begin
        Done    = 1'b1;
        DivZero = rDivZero;
        wNext   = IDLE;
      end
      default: wNext = IDLE;
    endcase
  end

  mult_div_datapath #(
    .WIDTH(WIDTH)
  ) uDatapath (
    .clk     (Clk),
    .rstN    (Reset),
    .load    (wLoad),
    .stepMult(wStepMult),
    .stepDiv (wStepDiv),
    .fix     (wFix),
    .op      (Op),
    .a       (A),
    .b       (B),
    .hi      (Hi),
    .lo      (Lo)
  );

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed multiply/divide engine with HI/LO result registers. It serves the MULT and DIV instructions of the multicycle CPU.
- The Control FSM sequences it over a Start/Busy/Done handshake and stalls in a wait state until Done.
- Hi/Lo feed the memToReg mux for MFHI/MFLO. DivZero feeds the exception path.

Parameters:
WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  request; sampled only in IDLE
Op  input  1  0 = MULT, 1 = DIV; sampled with Start
A  input  WIDTH  multiplicand / dividend (reg A output)
B  input  WIDTH  multiplier / divisor (reg B output)
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle completion pulse
DivZero  output  1  one-cycle pulse coincident with Done when DIV had B==0
Hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder
Lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient

Behaviour:
- Reset (Reset==0, asynchronous):
  - State goes to IDLE.
  - Hi, Lo, Busy, Done, DivZero, and all internal registers clear to 0.
  - Reset mid-operation aborts the operation: no Done, and Hi/Lo read 0.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - Start==1 latches A, B and Op, loads the counter with WIDTH, then goes to MULT or DIV.
  - Exception: DIV with B==0 goes directly to DONE with DivZero pending.
  - Start==0 stays in IDLE.
- A/B/Op changes after acceptance are ignored. Start outside IDLE is ignored; no queuing.
- MULT: radix-2 Booth, one step per cycle.
  - Internal register is {P_hi[W], P_lo[W], q-1}.
  - Each step: add/subtract the multiplicand into P_hi per {P_lo[0], q-1}, then arithmetic-shift the whole register right by 1.
  - Sum is computed at W+1 bits so the shift preserves the sign.
  - Counter decrements each step; at 0, go to FIX.
- DIV: restoring division on magnitudes |A|, |B|, one quotient bit per cycle; at counter 0, go to FIX.
  - |−2^(W−1)| is handled as the unsigned value 2^(W−1).
- FIX (1 cycle):
  - DIV: negate the quotient if sign(A)≠sign(B); the remainder takes the sign of A (truncation toward zero).
  - MULT: pass-through.
  - Write Hi/Lo; go to DONE.
- DONE (1 cycle): Done=1, Busy=1, DivZero=1 only for a divide by zero; go to IDLE.
- Latency, with Start accepted at edge t:
  - Done is high in cycle t+WIDTH+2 for both MULT and DIV (34 for WIDTH=32).
  - Divide by zero: Done is high in cycle t+1.
- Result rules:
  - Hi/Lo change only on the FIX→DONE edge and hold until the next successful completion.
  - Divide by zero leaves Hi/Lo unchanged.
  - DIV −2^(W−1) / −1 yields Lo=0x80000000, Hi=0, with no flag.
  - DivZero is the only error output; product overflow cannot occur.
- A back-to-back Start is accepted at the earliest in the cycle after DONE (IDLE).

Decomposition:
- Package mult_div_pkg holds:
  - state enum (IDLE, MULT, DIV, FIX, DONE);
  - OP_MULT=1'b0 and OP_DIV=1'b1;
  - functions for abs and conditional negate at WIDTH.
- Sub-module mult_div_datapath holds the operand, product and remainder registers and the add/sub/shift step, controlled by FSM strobes (load, step_mult, step_div, fix).
- The FSM, counter and handshake stay in mult_div_unit.

Test Plan (WIDTH=32):
- MULT 7 × 0xFFFFFFFD (−3) → Done in cycle t+34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high cycles t+1..t+34; DivZero=0.
- MULT 0x80000000 × 0x80000000 → Hi=0x40000000, Lo=0x00000000; MULT 0xFFFFFFFF × 0xFFFFFFFF → Hi=0, Lo=1.
- DIV 0xFFFFFFF9 (−7) / 2 → Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1); DIV 100/7 → Lo=14, Hi=2.
- Preload Hi/Lo via MULT 3×4, then DIV 5/0 → Done and DivZero both high in cycle t+1; Hi=0, Lo=12 unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- MULT in flight:
  - Pulse Start with new operands at cycle t+5 → ignored; the original result is reported.
  - Assert Reset at cycle t+10 → Busy=0 and Hi=Lo=0 immediately; no Done follows.
